muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and operand-class helpers.
package muldiv_unit_pkg;

  localparam int MD_WORD = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one FSM driving a shared double-width shift
// register (shift-add multiply, restoring divide), with sign fix-up and HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WORD = MD_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [WORD-1:0] A,
  input  logic [WORD-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo,
  output logic            div_zero
);

  localparam int CW = $clog2(WORD + 1);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*WORD-1:0] acc_q, acc_d;
  logic [WORD-1:0]   opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [WORD-1:0]   hi_q, hi_d;
  logic [WORD-1:0]   lo_q, lo_d;
  logic              div_zero_q, div_zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sa_s, sb_s, div_op_s;
  logic [WORD-1:0]   mag_a_s, mag_b_s;
  logic [WORD:0]     mul_sum_s;
  logic [2*WORD-1:0] mul_step_s, div_step_s;
  logic [WORD:0]     rem_s;
  logic              div_ge_s;
  logic [WORD-1:0]   div_diff_s;

  function automatic logic [WORD-1:0] neg_w(input logic [WORD-1:0] v);
    return {WORD{1'b0}} - v;
  endfunction

  function automatic logic [2*WORD-1:0] neg_dw(input logic [2*WORD-1:0] v);
    return {(2*WORD){1'b0}} - v;
  endfunction

  // Operand magnitudes/signs and the single-iteration datapath steps
  always_comb begin
    div_op_s   = is_div_op(op);
    sa_s       = is_signed_op(op) & A[WORD-1];
    sb_s       = is_signed_op(op) & B[WORD-1];
    mag_a_s    = sa_s ? neg_w(A) : A;
    mag_b_s    = sb_s ? neg_w(B) : B;
    // Multiply: conditional add into the upper half, then shift right with carry
    mul_sum_s  = {1'b0, acc_q[2*WORD-1:WORD]} + (acc_q[0] ? {1'b0, opb_q} : {(WORD+1){1'b0}});
    mul_step_s = {mul_sum_s, acc_q[WORD-1:1]};
    // Divide: partial remainder shifted left with the next dividend bit
    rem_s      = acc_q[2*WORD-1:WORD-1];
    div_ge_s   = rem_s >= {1'b0, opb_q};
    div_diff_s = rem_s[WORD-1:0] - opb_q;
    div_step_s = {(div_ge_s ? div_diff_s : rem_s[WORD-1:0]), acc_q[WORD-2:0], div_ge_s};
  end

  // Next-state, datapath and output register computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              acc_d      = {{WORD{1'b0}}, (div_op_s ? mag_a_s : mag_b_s)};
              opb_d      = div_op_s ? mag_b_s : mag_a_s;
              is_div_d   = div_op_s;
              neg_res_d  = sa_s ^ sb_s;
              neg_rem_d  = sa_s;
              dz_d       = div_op_s & (B == {WORD{1'b0}});
              div_zero_d = 1'b0;
              cnt_d      = {CW{1'b0}};
              state_d    = ST_RUN;
            end
            MD_MTHI: begin
              hi_d       = A;
              div_zero_d = 1'b0;
              state_d    = ST_DONE;
            end
            MD_MTLO: begin
              lo_d       = A;
              div_zero_d = 1'b0;
              state_d    = ST_DONE;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(WORD)) begin
          state_d = ST_FIX;
        end else begin
          acc_d = is_div_q ? div_step_s : mul_step_s;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div_q) begin
            // Divide by zero reports all-ones quotient regardless of sign
            lo_d = dz_q ? {WORD{1'b1}} : (neg_res_q ? neg_w(acc_q[WORD-1:0]) : acc_q[WORD-1:0]);
            hi_d = neg_rem_q ? neg_w(acc_q[2*WORD-1:WORD]) : acc_q[2*WORD-1:WORD];
          end else begin
            {hi_d, lo_d} = neg_res_q ? neg_dw(acc_q) : acc_q;
          end
          div_zero_d = dz_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*WORD){1'b0}};
      opb_q      <= {WORD{1'b0}};
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= {WORD{1'b0}};
      lo_q       <= {WORD{1'b0}};
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: plain-arithmetic reference model, directed
// corner cases, randomized operations, flush and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] A, B, hi, lo;
  logic        busy, done, div_zero;

  muldiv_unit #(.WORD(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural reference: HI/LO/div_zero after an accepted operation
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      x, y, q, r;
    logic [63:0] p;
    case (o)
      MD_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
      end
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1;
        end else begin
          if (o == MD_DIV) begin
            x = longint'($signed(a)); y = longint'($signed(b));
          end else begin
            x = longint'({32'd0, a}); y = longint'({32'd0, b});
          end
          q = x / y; r = x % y;
          p = 64'(q); m_lo = p[31:0];
          p = 64'(r); m_hi = p[31:0];
          m_dz = 1'b0;
        end
      end
      MD_MTHI: begin m_hi = a; m_dz = 1'b0; end
      MD_MTLO: begin m_lo = a; m_dz = 1'b0; end
      default: ;
    endcase
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: cycle %0d hi=%h lo=%h", cyc, hi, lo);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_zero", 64'(div_zero), 64'(mon_e.dz));
        chk("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || done !== 1'b0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("idle_timeout", 64'(w), 64'(0));
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track && o <= MD_MTLO) begin
      model(o, a, b);
      e.hi = m_hi; e.lo = m_lo; e.dz = m_dz;
      e.due = cyc + ((o == MD_MTHI || o == MD_MTLO) ? 0 : 34);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_hi"}, 64'(hi), 64'(0));
    chk({tag, "_lo"}, 64'(lo), 64'(0));
    chk({tag, "_dz"}, 64'(div_zero), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    issue(MD_MULT,  32'hFFFF_FFFD, 32'd7,         1'b1);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1);
    issue(MD_DIVU,  32'd7,         32'd0,         1'b1);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd0,         1'b1);
    drain();

    // Start while in DONE is ignored
    issue(MD_MTHI, 32'hCAFE_0001, 32'd0, 1'b1);
    @(negedge clk);
    start = 1'b1; op = MD_MTLO; A = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    issue(MD_MTHI, 32'h0BAD_F00D, 32'd0, 1'b1);
    drain();

    // Start while busy is ignored
    issue(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (5) @(negedge clk);
    chk("busy_run", 64'(busy), 64'(1));
    start = 1'b1; op = MD_DIVU; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Flush mid-multiply
    issue(MD_MULTU, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    repeat (40) @(negedge clk);
    chk("flush_no_done", 64'(done), 64'(0));

    // Flush and start together in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MD_MTHI; A = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_done", 64'(done), 64'(0));
    chk("flush_start_hi", 64'(hi), 64'(m_hi));

    // Randomized operations, including undefined codes and corner operands
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue(o, a, b, 1'b1);
    end
    drain();

    // Reset in the middle of a divide
    issue(MD_DIV, 32'h7654_3210, 32'd13, 1'b0);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(MD_MTLO, 32'h1234_5678, 32'd0, 1'b1);
    chk("mt_busy_a", 64'(busy), 64'(0));
    @(negedge clk);
    chk("mt_busy_b", 64'(busy), 64'(0));
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
